// File: rtl/cmsdk_uart_stimulus_if.sv
// Bench-side byte write port of the UART stimulus transmitter.
// Valid/ready: a byte transfers on a rising clock edge when DATA_VALID && DATA_READY;
// DATA_VALID while DATA_READY is low is simply dropped, so the master need not hold it.
interface cmsdk_uart_stimulus_if;
    logic [7:0] DATA_IN;
    logic       DATA_VALID;
    logic       DATA_READY;

    modport master (output DATA_IN, output DATA_VALID, input DATA_READY);
    modport slave  (input DATA_IN, input DATA_VALID, output DATA_READY);
endinterface

// File: rtl/cmsdk_uart_stimulus.sv
// Testbench-side UART transmitter: byte FIFO feeding an 8-bit serialiser with
// optional parity, producing a registered TXD line for the MCU UART RXD pin.
module cmsdk_uart_stimulus #(
    parameter int BAUDDIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                        CLK,
    input  logic                        RESETn,
    input  logic                        ENABLE,
    cmsdk_uart_stimulus_if.slave        wr,
    output logic                        TXD,
    output logic                        BUSY,
    output logic                        TX_DONE,
    output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
    output logic [15:0]                 BYTE_COUNT,
    output logic [2:0]                  state_dbg
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (BAUDDIV > 2) ? $clog2(BAUDDIV) : 1;

    if (BAUDDIV < 2) begin : g_bad_bauddiv
        $error("cmsdk_uart_stimulus: BAUDDIV must be >= 2");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cmsdk_uart_stimulus: FIFO_DEPTH must be a power of 2 in 2..64");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic           txd_q, txd_d;
    logic           pop, push, bit_end, fifo_empty;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level_q;
    logic [15:0]    count_q;
    logic [7:0]     mem [FIFO_DEPTH];

    assign bit_end    = (baud_q == CW'(BAUDDIV - 1));
    assign fifo_empty = (level_q == '0);
    // Ready comes from the registered level only, so a pop never opens a slot in the same cycle.
    assign wr.DATA_READY = (level_q != LW'(FIFO_DEPTH));
    assign push       = wr.DATA_VALID && wr.DATA_READY;

    always_comb begin
        state_d = state_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ENABLE && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d = shift_q[bit_q + 3'd1];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                // Back-to-back frames: the next start bit follows the stop bit directly.
                if (bit_end) begin
                    if (ENABLE && !fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            txd_q   <= 1'b1;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            if (state_q == S_IDLE || bit_end) baud_q <= '0;
            else                              baud_q <= baud_q + 1'b1;
            if (state_q != S_DATA) bit_q <= '0;
            else if (bit_end)      bit_q <= bit_q + 3'd1;
            if (pop) begin
                shift_q <= mem[rd_ptr];
                par_q   <= (^mem[rd_ptr]) ^ PARITY_ODD;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (TX_DONE) count_q <= count_q + 16'd1;
        end
    end

    // Storage is not reset; a flush is just the pointer and level clear above.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr.DATA_IN;
    end

    assign TX_DONE    = (state_q == S_STOP) && bit_end;
    assign TXD        = txd_q;
    assign BUSY       = (state_q != S_IDLE) || !fifo_empty;
    assign FIFO_LEVEL = level_q;
    assign BYTE_COUNT = count_q;
    assign state_dbg  = state_q;
endmodule

// File: doc/cmsdk_uart_stimulus.md
Name: cmsdk_uart_stimulus

Overview:
Testbench-side UART transmitter. It is the counterpart of the UART capture device: it serialises bytes from a bench-side write port onto a single TXD line. TXD drives the MCU UART RXD pin (P1[0]), so scripted input reaches software under test. It has a small byte FIFO, a programmable baud divider, optional parity, and 8N1 framing by default.

Parameters:
BAUDDIV, 16, CLK cycles per bit period; legal values are >= 2, and elaboration fails otherwise.
FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, range 2..64.
PARITY_EN, 0, 1 inserts a parity bit between D7 and the stop bit.
PARITY_ODD, 0, 0 selects even parity and 1 selects odd; ignored when PARITY_EN=0.

Ports:
CLK  input  1  bench clock; same clock as PCLK of the MCU UART.
RESETn  input  1  asynchronous active-low reset.
ENABLE  input  1  1 allows new frames to start.
DATA_IN  input  8  byte to transmit.
DATA_VALID  input  1  write request.
DATA_READY  output  1  FIFO not full.
TXD  output  1  serial output; idles high.
BUSY  output  1  a frame is in progress or the FIFO is non-empty.
TX_DONE  output  1  one-cycle pulse at the end of each stop bit.
FIFO_LEVEL  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
BYTE_COUNT  output  16  count of frames completed; wraps.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - TXD=1, DATA_READY=1, BUSY=0, TX_DONE=0, FIFO_LEVEL=0, BYTE_COUNT=0.
  - FSM goes to IDLE; FIFO pointers and baud/bit counters clear; the FIFO is flushed.
- Write handshake:
  - A byte is accepted on a rising CLK edge when DATA_VALID && DATA_READY.
  - DATA_READY = (FIFO_LEVEL != FIFO_DEPTH), taken from the registered level.
  - While full, a pop in the same cycle does not open a push slot; READY rises on the following cycle.
  - DATA_VALID while not ready is ignored; no overflow flag.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when ENABLE && FIFO_LEVEL != 0. On this edge the head byte is popped into the shift register and TXD goes 0.
  - Write into an empty FIFO at edge N with IDLE && ENABLE: pop at edge N+1, TXD falls after edge N+1 (one-cycle latency).
  - Each state holds for exactly BAUDDIV cycles, counted by the baud counter (0..BAUDDIV-1), which reloads on every bit boundary.
  - START: TXD=0. Then DATA.
  - DATA: 8 bits, LSB first, via a 3-bit bit counter. Then PARITY if PARITY_EN, else STOP.
  - PARITY: TXD = ^byte XOR PARITY_ODD. Then STOP.
  - STOP: TXD=1. On its last cycle TX_DONE=1 and BYTE_COUNT increments, wrapping 0xFFFF -> 0.
    - If ENABLE && FIFO non-empty: go directly to START. The next start bit follows with zero idle cycles.
    - Otherwise go to IDLE.
- Frame length is 10*BAUDDIV cycles, or 11*BAUDDIV with parity.
- ENABLE deasserted mid-frame: the current frame completes, then the FSM rests in IDLE. FIFO contents are retained and writes still accepted.
- Push and pop in the same cycle (not full): FIFO_LEVEL stays unchanged.
- BUSY = (state != IDLE) || (FIFO_LEVEL != 0).
- TXD is registered and glitch-free. It changes only on CLK edges at bit boundaries.

Test Plan:
1. BAUDDIV=16, write 0x55 at edge 0, ENABLE=1 -> TXD low for edges 1..16; then 1,0,1,0,1,0,1,0 each 16 cycles; stop high; TX_DONE pulse at cycle 160; BYTE_COUNT=1; BUSY falls at cycle 161.
2. ENABLE=0, write 0x01..0x05 back-to-back -> first 4 accepted, DATA_READY=0 after the 4th, 0x05 dropped, FIFO_LEVEL=4. Set ENABLE=1 -> DATA_READY=1 one cycle after the first pop; frames 0x01..0x04 are contiguous with no idle gaps; 4 TX_DONE pulses 160 cycles apart.
3. PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, frame 176 cycles. PARITY_ODD=1, byte 0x07 -> parity bit 0.
4. Assert RESETn low mid-DATA of 0xA3 with 2 bytes queued -> TXD=1 immediately (asynchronous), FIFO_LEVEL=0, BYTE_COUNT=0. After release, no frame starts.
5. Loopback into a UART capture instance at matching baud, send "Hi\n" (0x48,0x69,0x0A) -> capture prints "Hi"; BYTE_COUNT=3.
6. Preload BYTE_COUNT near wrap by sending 65537 frames with BAUDDIV=2 -> BYTE_COUNT=1 at end; no X on any output throughout.
